// File: rtl/prog_loader_if.sv
// Byte stream carrying the program image from its source into prog_loader.
// Master drives valid/data, slave answers with ready.
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: streams a length-prefixed program into a 16-byte instruction memory, zero-fills the rest.
// Define LOADER_CSUM_EN to require a trailing mod-256 checksum byte (adds the CSUM state).
//
// state | meaning
// IDLE  | after reset, waiting for start, core held in reset
// LEN   | waiting for the length byte N
// DATA  | accepting and writing N instruction bytes
// CSUM  | waiting for the checksum byte (LOADER_CSUM_EN only)
// FILL  | writing 8'h00 to addresses N..15
// DONE  | load succeeded, core released
// ERR   | load failed, core held in reset
module prog_loader (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    prog_loader_if.slave src,
    output logic         imem_we,
    output logic [3:0]   imem_waddr,
    output logic [7:0]   imem_wdata,
    output logic         core_rst,
    output logic         busy,
    output logic         done,
    output logic         err
);

`ifdef LOADER_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_FILL, S_DONE, S_ERR} state_t;
`endif

    state_t     state, state_nxt;
    logic [4:0] len, len_nxt;
    logic [4:0] idx, idx_nxt;
    logic       we_nxt;
    logic [3:0] waddr_nxt;
    logic [7:0] wdata_nxt;
    logic       accept;
`ifdef LOADER_CSUM_EN
    logic [7:0] sum, sum_nxt;
`endif

`ifdef LOADER_CSUM_EN
    assign src.in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
`else
    assign src.in_ready = (state == S_LEN) || (state == S_DATA);
`endif
    assign accept   = src.in_valid && src.in_ready;
    assign busy     = src.in_ready || (state == S_FILL);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign core_rst = (state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
`ifdef LOADER_CSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            idx        <= idx_nxt;
            imem_we    <= we_nxt;
            imem_waddr <= waddr_nxt;
            imem_wdata <= wdata_nxt;
`ifdef LOADER_CSUM_EN
            sum        <= sum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        waddr_nxt = imem_waddr;
        wdata_nxt = imem_wdata;
`ifdef LOADER_CSUM_EN
        sum_nxt   = sum;
`endif
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_LEN;
                    idx_nxt   = '0;
`ifdef LOADER_CSUM_EN
                    sum_nxt   = '0;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    if ((src.in_data == 8'd0) || (src.in_data > 8'd16)) begin
                        state_nxt = S_ERR;
                    end else begin
                        len_nxt   = src.in_data[4:0];
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = idx[3:0];
                    wdata_nxt = src.in_data;
                    idx_nxt   = idx + 5'd1;
`ifdef LOADER_CSUM_EN
                    sum_nxt   = sum + src.in_data;
                    if (idx + 5'd1 == len) state_nxt = S_CSUM;
`else
                    // A full 16-byte image leaves nothing to fill.
                    if (idx + 5'd1 == len) state_nxt = (len == 5'd16) ? S_DONE : S_FILL;
`endif
                end
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (src.in_data != sum) state_nxt = S_ERR;
                    else                    state_nxt = (idx == 5'd16) ? S_DONE : S_FILL;
                end
            end
`endif
            S_FILL: begin
                we_nxt    = 1'b1;
                waddr_nxt = idx[3:0];
                wdata_nxt = 8'h00;
                idx_nxt   = idx + 5'd1;
                if (idx == 5'd15) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 start  input  1  single-cycle load request.
REQ-003 in_valid  input  1  source byte valid; in_data  input  8  source byte; in_ready  output  1  loader accepts byte.
REQ-004 imem_we  output  1  instruction-memory write strobe; imem_waddr  output  4  write address; imem_wdata  output  8  write data.
REQ-005 core_rst  output  1  active-high hold-in-reset for the processor core.
REQ-006 busy  output  1  load in progress; done  output  1  load succeeded (sticky); err  output  1  load failed (sticky).

Function
REQ-007 A byte SHALL transfer only on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 in LEN, DATA and CSUM and 0 otherwise.
REQ-008 Stream format SHALL be: one length byte N, then N instruction bytes (address 0 first), then one checksum byte (only when LOADER_CSUM_EN is defined).
REQ-009 States SHALL be IDLE, LEN, DATA, CSUM, FILL, DONE, ERR.
REQ-010 start in IDLE, DONE or ERR SHALL move to LEN on the next edge, clear done, err, byte index and running sum, and set core_rst=1; start in any other state SHALL be ignored.
REQ-011 LEN: accepted N with 1<=N<=16 SHALL latch N and go to DATA; N=0 or N>16 SHALL go to ERR.
REQ-012 DATA: each accepted byte SHALL be written to the instruction memory, and the running sum SHALL be updated as (sum + byte) mod 256; after the Nth byte the next state SHALL be CSUM when LOADER_CSUM_EN is defined, otherwise FILL.
REQ-013 CSUM: accepted byte equal to the running sum SHALL go to FILL; any other value SHALL go to ERR.
REQ-014 FILL: SHALL write 8'h00 to addresses N..15, one per cycle, in ascending order, then go to DONE; when N=16 it SHALL go to DONE after zero cycles of writing.
REQ-015 Write timing: imem_we SHALL be registered, asserted for exactly one cycle, in the cycle after the accepting edge, with imem_waddr/imem_wdata valid in that same cycle; each FILL write SHALL be one cycle.
REQ-016 The byte index SHALL be 5 bits wide internally and SHALL never wrap past address 15; imem_waddr SHALL carry the low 4 bits.
REQ-017 busy SHALL be 1 in LEN, DATA, CSUM and FILL, and 0 otherwise.
REQ-018 DONE: done=1, core_rst=0, held until the next start.
REQ-019 ERR: err=1, core_rst=1, no further memory writes, held until the next start.
REQ-020 When in_valid=0 in an accepting state, the block SHALL wait indefinitely without changing state.

Reset
REQ-021 rst_n=0 at any time, including mid-load, SHALL immediately force: state IDLE, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0, index=0, sum=0.
REQ-022 After reset is released, the block SHALL stay in IDLE with core_rst=1 until a load completes.

Configuration
REQ-023 Macro LOADER_CSUM_EN defined: the CSUM state and checksum byte SHALL be present, as described in REQ-012 and REQ-013.
REQ-024 Macro LOADER_CSUM_EN undefined: there SHALL be no CSUM state and no sum logic; the stream SHALL end after N instruction bytes, and a checksum mismatch SHALL never cause ERR.

Verification
REQ-025 (CSUM_EN) start; stream 03,04,6C,92,02 with in_valid always high -> writes addr0=04, addr1=6C, addr2=92, then addr3..15=00; done=1, core_rst=0, err=0.
REQ-026 (CSUM_EN) start; stream 02,10,20,31 -> ERR after the checksum byte, err=1, core_rst=1, only addr0=10 and addr1=20 written, no FILL writes.
REQ-027 start; length byte 00, and in a separate run length byte 11 -> ERR at the LEN edge, no imem_we pulse.
REQ-028 Length 10 (hex) with 16 bytes plus correct checksum, in_valid toggled every other cycle -> 16 writes to addresses 0..15 in order, no FILL writes, done=1; in_ready stays 1 across the idle cycles.
REQ-029 rst_n asserted after the 2nd data byte of a 5-byte load -> all outputs at their reset values immediately; a subsequent clean load of 01,AA(,AA) -> done=1, addr0=AA.
REQ-030 start pulsed during DATA -> ignored, load completes normally; start pulsed in DONE -> done cleared, core_rst=1, state LEN.
